// File: rtl/eth_rx_sched.sv
// Receive-path scheduler: ping-pong capture banks, parser kick/timeout, and
// payload hand-off to the consumer with a saturating dropped-frame counter.
module eth_rx_sched #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 1023,
    parameter int DROP_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_done,
    input  logic [ADDR_W-1:0] rx_len,
    output logic              rx_wr_bank,
    output logic              rx_full,
    output logic              parse_bank,
    output logic              newpacket,
    input  logic              parse_done,
    input  logic              parse_valid,
    input  logic [ADDR_W-1:0] parse_last,
    output logic              parse_abort,
    output logic              pay_valid,
    output logic [ADDR_W-1:0] pay_len,
    input  logic              pay_ready,
    input  logic              pay_done,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              busy
);

    localparam int TIMER_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_KICK  = 3'd1;
    localparam logic [2:0] ST_PARSE = 3'd2;
    localparam logic [2:0] ST_OFFER = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    logic [2:0]         state_r;
    logic [2:0]         state_nxt_s;
    logic [1:0]         occ_r;
    logic [1:0]         occ_nxt_s;
    logic [1:0]         occ_clr_s;
    logic [1:0]         occ_set_s;
    logic               wr_ptr_r;
    logic               rd_ptr_r;
    logic [TIMER_W-1:0] timer_r;
    logic [TIMER_W-1:0] timer_nxt_s;
    logic               cap_ok_s;
    logic               cap_drop_s;
    logic               parse_drop_s;
    logic               abort_s;
    logic               pay_latch_s;
    logic               rd_toggle_s;
    logic [1:0]         drop_inc_s;
    logic [DROP_W:0]    drop_sum_s;
    logic [DROP_W-1:0]  drop_nxt_s;

    // Capture side: accept a frame into the write bank or flag it as dropped.
    always_comb begin
        cap_ok_s   = 1'b0;
        cap_drop_s = 1'b0;
        occ_set_s  = 2'b00;
        if (rx_done) begin
            if (!occ_r[wr_ptr_r] && (rx_len != {ADDR_W{1'b0}})) begin
                cap_ok_s  = 1'b1;
                occ_set_s = wr_ptr_r ? 2'b10 : 2'b01;
            end else begin
                cap_drop_s = 1'b1;
            end
        end else begin
            cap_ok_s = 1'b0;
        end
        // A clear from PARSE and a set from capture never target the same bank.
        occ_nxt_s = (occ_r & ~occ_clr_s) | occ_set_s;
    end

    // Scheduler FSM next-state and per-cycle events.
    always_comb begin
        state_nxt_s  = state_r;
        timer_nxt_s  = timer_r;
        occ_clr_s    = 2'b00;
        rd_toggle_s  = 1'b0;
        parse_drop_s = 1'b0;
        abort_s      = 1'b0;
        pay_latch_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (occ_r[rd_ptr_r]) begin
                    state_nxt_s = ST_KICK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_KICK: begin
                timer_nxt_s = {TIMER_W{1'b0}};
                state_nxt_s = ST_PARSE;
            end
            ST_PARSE: begin
                timer_nxt_s = timer_r + TIMER_W'(1);
                if (parse_done) begin
                    occ_clr_s   = rd_ptr_r ? 2'b10 : 2'b01;
                    rd_toggle_s = 1'b1;
                    if (parse_valid) begin
                        pay_latch_s = 1'b1;
                        state_nxt_s = ST_OFFER;
                    end else begin
                        parse_drop_s = 1'b1;
                        state_nxt_s  = ST_IDLE;
                    end
                end else if (timer_r == TIMER_LAST) begin
                    occ_clr_s    = rd_ptr_r ? 2'b10 : 2'b01;
                    rd_toggle_s  = 1'b1;
                    parse_drop_s = 1'b1;
                    abort_s      = 1'b1;
                    state_nxt_s  = ST_IDLE;
                end else begin
                    state_nxt_s = ST_PARSE;
                end
            end
            ST_OFFER: begin
                if (pay_ready) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_OFFER;
                end
            end
            ST_DRAIN: begin
                if (pay_done) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Saturating drop counter: capture and parse may both drop in one cycle.
    always_comb begin
        drop_inc_s = {1'b0, cap_drop_s} + {1'b0, parse_drop_s};
        drop_sum_s = {1'b0, drop_cnt} + (DROP_W + 1)'(drop_inc_s);
        if (drop_sum_s[DROP_W]) begin
            drop_nxt_s = {DROP_W{1'b1}};
        end else begin
            drop_nxt_s = drop_sum_s[DROP_W-1:0];
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            occ_r       <= 2'b00;
            wr_ptr_r    <= 1'b0;
            rd_ptr_r    <= 1'b0;
            timer_r     <= {TIMER_W{1'b0}};
            rx_wr_bank  <= 1'b0;
            rx_full     <= 1'b0;
            parse_bank  <= 1'b0;
            newpacket   <= 1'b0;
            parse_abort <= 1'b0;
            pay_valid   <= 1'b0;
            pay_len     <= {ADDR_W{1'b0}};
            drop_cnt    <= {DROP_W{1'b0}};
            busy        <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            occ_r       <= occ_nxt_s;
            wr_ptr_r    <= wr_ptr_r ^ cap_ok_s;
            rd_ptr_r    <= rd_ptr_r ^ rd_toggle_s;
            timer_r     <= timer_nxt_s;
            rx_wr_bank  <= wr_ptr_r ^ cap_ok_s;
            rx_full     <= &occ_nxt_s;
            newpacket   <= (state_nxt_s == ST_KICK);
            parse_abort <= abort_s;
            pay_valid   <= (state_nxt_s == ST_OFFER);
            drop_cnt    <= drop_nxt_s;
            busy        <= (state_nxt_s != ST_IDLE);
            if (state_nxt_s == ST_KICK) begin
                parse_bank <= rd_ptr_r;
            end
            if (pay_latch_s) begin
                pay_len <= parse_last;
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_sched.sv
// Bench for eth_rx_sched: a cycle table for the basic flow, hand sequences for
// the multi-cycle corners, and queues checking kick order and payload lengths.
module tb_eth_rx_sched;

    localparam int ADDR_W  = 9;
    localparam int TIMEOUT = 16;
    localparam int DROP_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_done = 1'b0;
    logic [ADDR_W-1:0] rx_len = '0;
    logic              rx_wr_bank;
    logic              rx_full;
    logic              parse_bank;
    logic              newpacket;
    logic              parse_done = 1'b0;
    logic              parse_valid = 1'b0;
    logic [ADDR_W-1:0] parse_last = '0;
    logic              parse_abort;
    logic              pay_valid;
    logic [ADDR_W-1:0] pay_len;
    logic              pay_ready = 1'b0;
    logic              pay_done = 1'b0;
    logic [DROP_W-1:0] drop_cnt;
    logic              busy;

    eth_rx_sched #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .DROP_W(DROP_W)) dut (
        .clk(clk), .rst(rst), .rx_done(rx_done), .rx_len(rx_len),
        .rx_wr_bank(rx_wr_bank), .rx_full(rx_full), .parse_bank(parse_bank),
        .newpacket(newpacket), .parse_done(parse_done), .parse_valid(parse_valid),
        .parse_last(parse_last), .parse_abort(parse_abort), .pay_valid(pay_valid),
        .pay_len(pay_len), .pay_ready(pay_ready), .pay_done(pay_done),
        .drop_cnt(drop_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              rx_done;
        logic [ADDR_W-1:0] rx_len;
        logic              pd;
        logic              pv;
        logic [ADDR_W-1:0] pl;
        logic              prdy;
        logic              pdone;
        logic              acc;
        logic              pay;
        logic              e_wrb;
        logic              e_full;
        logic              e_pb;
        logic              e_np;
        logic              e_ab;
        logic              e_pv;
        logic [ADDR_W-1:0] e_plen;
        logic [DROP_W-1:0] e_drop;
        logic              e_busy;
    } vec_t;

    vec_t vecs[12];
    int   checks = 0;
    int   failures = 0;
    int   bank_q[$];
    int   len_q[$];
    int   acc_cnt = 0;
    int   abort_seen = 0;
    logic pv_d = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rx_done = 1'b0; rx_len = '0; parse_done = 1'b0; parse_valid = 1'b0;
        parse_last = '0; pay_ready = 1'b0; pay_done = 1'b0;
    endtask

    task automatic push_bank();
        bank_q.push_back(acc_cnt % 2);
        acc_cnt++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        bank_q.delete();
        len_q.delete();
        acc_cnt = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input logic [ADDR_W-1:0] len, input logic acc);
        rx_done = 1'b1;
        rx_len  = len;
        if (acc) push_bank();
        tick();
        rx_done = 1'b0;
        rx_len  = '0;
    endtask

    task automatic wait_np(input string name);
        int n;
        n = 0;
        while (newpacket !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(name, newpacket, 1'b1);
    endtask

    task automatic finish_payload();
        pay_ready = 1'b1;
        tick();
        pay_ready = 1'b0;
        pay_done = 1'b1;
        tick();
        pay_done = 1'b0;
    endtask

    // Scoreboard: kicks must come in accepted-frame order; payload lengths in parse order.
    always @(negedge clk) begin
        if (rst) begin
            pv_d <= 1'b0;
        end else begin
            if (newpacket) begin
                chk("np_expected", bank_q.size() > 0, 1'b1);
                if (bank_q.size() > 0) chk("np_parse_bank", parse_bank, bank_q.pop_front());
            end
            if (pay_valid && !pv_d) begin
                chk("pay_expected", len_q.size() > 0, 1'b1);
                if (len_q.size() > 0) chk("pay_len_sb", pay_len, len_q.pop_front());
            end
            if (parse_abort) abort_seen++;
            pv_d <= pay_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int early;
        int bad;
        int nps;
        int ab0;

        vecs[0]  = '{1'b1, 9'd40,  1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0,   4'd0, 1'b0};
        vecs[1]  = '{1'b0, 9'd0,   1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'd0,   4'd0, 1'b1};
        vecs[2]  = '{1'b0, 9'd0,   1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0,   4'd0, 1'b1};
        vecs[3]  = '{1'b0, 9'd0,   1'b1, 1'b1, 9'd299, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'd299, 4'd0, 1'b1};
        vecs[4]  = '{1'b0, 9'd0,   1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'd299, 4'd0, 1'b1};
        vecs[5]  = '{1'b0, 9'd0,   1'b0, 1'b0, 9'd0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd299, 4'd0, 1'b1};
        vecs[6]  = '{1'b0, 9'd0,   1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd299, 4'd0, 1'b1};
        vecs[7]  = '{1'b0, 9'd0,   1'b0, 1'b0, 9'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd299, 4'd0, 1'b0};
        vecs[8]  = '{1'b0, 9'd0,   1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd299, 4'd0, 1'b0};
        vecs[9]  = '{1'b1, 9'd0,   1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd299, 4'd1, 1'b0};
        vecs[10] = '{1'b0, 9'd0,   1'b0, 1'b0, 9'd0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd299, 4'd1, 1'b0};
        vecs[11] = '{1'b0, 9'd0,   1'b1, 1'b1, 9'd5,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd299, 4'd1, 1'b0};

        do_reset();
        chk("rst_busy", busy, 1'b0);
        chk("rst_drop", drop_cnt, 4'd0);
        chk("rst_pay_valid", pay_valid, 1'b0);
        chk("rst_newpacket", newpacket, 1'b0);

        // Single frame flow plus ignored inputs outside their states.
        for (int i = 0; i < 12; i++) begin
            rx_done = vecs[i].rx_done; rx_len = vecs[i].rx_len;
            parse_done = vecs[i].pd; parse_valid = vecs[i].pv; parse_last = vecs[i].pl;
            pay_ready = vecs[i].prdy; pay_done = vecs[i].pdone;
            if (vecs[i].acc) push_bank();
            if (vecs[i].pay) len_q.push_back(int'(vecs[i].pl));
            tick();
            chk($sformatf("vec%0d_rx_wr_bank", i), rx_wr_bank, vecs[i].e_wrb);
            chk($sformatf("vec%0d_rx_full", i), rx_full, vecs[i].e_full);
            chk($sformatf("vec%0d_parse_bank", i), parse_bank, vecs[i].e_pb);
            chk($sformatf("vec%0d_newpacket", i), newpacket, vecs[i].e_np);
            chk($sformatf("vec%0d_parse_abort", i), parse_abort, vecs[i].e_ab);
            chk($sformatf("vec%0d_pay_valid", i), pay_valid, vecs[i].e_pv);
            chk($sformatf("vec%0d_pay_len", i), pay_len, vecs[i].e_plen);
            chk($sformatf("vec%0d_drop_cnt", i), drop_cnt, vecs[i].e_drop);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
        end
        clear_inputs();

        // Back-to-back frames with overflow, then a non-UDP frame.
        do_reset();
        send(9'd10, 1'b1);
        send(9'd20, 1'b1);
        chk("b2b_full", rx_full, 1'b1);
        send(9'd30, 1'b0);
        chk("b2b_overflow_drop", drop_cnt, 4'd1);
        chk("b2b_still_full", rx_full, 1'b1);
        parse_done = 1'b1; parse_valid = 1'b0;
        tick();
        clear_inputs();
        chk("nonudp_drop", drop_cnt, 4'd2);
        chk("nonudp_freed", rx_full, 1'b0);
        chk("nonudp_no_pay", pay_valid, 1'b0);
        wait_np("nonudp_next_kick");
        chk("nonudp_bank1", parse_bank, 1'b1);
        tick();
        parse_done = 1'b1; parse_valid = 1'b1; parse_last = 9'd77;
        len_q.push_back(77);
        tick();
        clear_inputs();
        chk("b2b_pay_valid", pay_valid, 1'b1);
        chk("b2b_pay_len", pay_len, 9'd77);
        finish_payload();
        chk("b2b_idle", busy, 1'b0);
        chk("b2b_wr_bank", rx_wr_bank, 1'b0);

        // Parse timeout: abort pulse 16 cycles after PARSE entry.
        do_reset();
        send(9'd5, 1'b1);
        wait_np("to_kick");
        tick();
        early = 0;
        for (int i = 1; i < TIMEOUT; i++) begin
            tick();
            if (parse_abort) early++;
        end
        chk("to_no_early_abort", early, 0);
        tick();
        chk("to_abort_pulse", parse_abort, 1'b1);
        chk("to_drop", drop_cnt, 4'd1);
        chk("to_idle", busy, 1'b0);
        tick();
        chk("to_abort_one_cycle", parse_abort, 1'b0);

        // parse_done in the exact timeout cycle wins.
        send(9'd6, 1'b1);
        wait_np("tod_kick");
        tick();
        for (int i = 1; i < TIMEOUT; i++) tick();
        parse_done = 1'b1; parse_valid = 1'b1; parse_last = 9'd123;
        len_q.push_back(123);
        tick();
        clear_inputs();
        chk("tod_no_abort", parse_abort, 1'b0);
        chk("tod_pay_valid", pay_valid, 1'b1);
        chk("tod_pay_len", pay_len, 9'd123);
        chk("tod_drop", drop_cnt, 4'd1);
        finish_payload();
        chk("tod_idle", busy, 1'b0);

        // Payload backpressure with the other bank waiting.
        do_reset();
        send(9'd11, 1'b1);
        wait_np("bp_kick");
        tick();
        send(9'd12, 1'b1);
        parse_done = 1'b1; parse_valid = 1'b1; parse_last = 9'd200;
        len_q.push_back(200);
        tick();
        clear_inputs();
        chk("bp_pay_valid", pay_valid, 1'b1);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (pay_valid !== 1'b1 || pay_len !== 9'd200 || newpacket !== 1'b0) bad++;
        end
        chk("bp_stable", bad, 0);
        pay_ready = 1'b1;
        tick();
        pay_ready = 1'b0;
        chk("bp_drain_pay_valid", pay_valid, 1'b0);
        nps = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (newpacket) nps++;
        end
        chk("bp_no_kick_in_drain", nps, 0);
        pay_done = 1'b1;
        tick();
        pay_done = 1'b0;
        wait_np("bp_kick_after_done");
        chk("bp_bank1", parse_bank, 1'b1);
        tick();
        parse_done = 1'b1; parse_valid = 1'b0;
        tick();
        clear_inputs();
        chk("bp_drop", drop_cnt, 4'd1);

        // Reset in the middle of PARSE.
        send(9'd13, 1'b1);
        wait_np("rmp_kick");
        tick();
        tick();
        ab0 = abort_seen;
        rst = 1'b1;
        bank_q.delete();
        len_q.delete();
        acc_cnt = 0;
        tick();
        chk("rmp_rx_wr_bank", rx_wr_bank, 1'b0);
        chk("rmp_rx_full", rx_full, 1'b0);
        chk("rmp_parse_bank", parse_bank, 1'b0);
        chk("rmp_newpacket", newpacket, 1'b0);
        chk("rmp_parse_abort", parse_abort, 1'b0);
        chk("rmp_pay_valid", pay_valid, 1'b0);
        chk("rmp_pay_len", pay_len, 9'd0);
        chk("rmp_drop", drop_cnt, 4'd0);
        chk("rmp_busy", busy, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("rmp_no_abort", abort_seen - ab0, 0);
        chk("rmp_stays_idle", busy, 1'b0);

        // Double drop in one cycle, then saturation and reset of the counter.
        do_reset();
        send(9'd14, 1'b1);
        wait_np("sat_kick");
        tick();
        parse_done = 1'b1; parse_valid = 1'b0;
        rx_done = 1'b1; rx_len = 9'd0;
        tick();
        clear_inputs();
        chk("double_drop", drop_cnt, 4'd2);
        for (int i = 0; i < 13; i++) send(9'd0, 1'b0);
        chk("sat_reach", drop_cnt, 4'd15);
        send(9'd0, 1'b0);
        chk("sat_hold", drop_cnt, 4'd15);
        rst = 1'b1;
        tick();
        chk("sat_reset", drop_cnt, 4'd0);
        rst = 1'b0;
        tick();

        chk("bank_q_empty", bank_q.size(), 0);
        chk("len_q_empty", len_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
